// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types; word_t is the architectural word used for the
// instruction sideband carried by pipeline-stage buffers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/pipe_buf_pkg.sv
// Constants and helpers shared by pipe_stage_buf and its performance-counter
// sub-module.
package pipe_buf_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          PERF_W    = 32;

    // Pointer width for an n-entry ring; a single entry still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_buf_perf.sv
// Saturating stall/bubble counters observing a pipe_stage_buf output port.
// Cleared only by RST; flush never touches them.
module pipe_buf_perf
    import pipe_buf_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              out_valid,
    input  logic              out_ready,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] bubble_cnt
);

    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = out_valid & ~out_ready;
    assign bubble_evt = ~out_valid & ~flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (bubble_evt && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry pipeline-stage buffer with valid/ready handshake, flush
// and instruction sideband. Define PIPE_BUF_PERF_EN to add stall/bubble counters.
module pipe_stage_buf
    import cpu_types_pkg::*;
    import pipe_buf_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 2,
    parameter int INSTR_W = $bits(word_t)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_BUF_PERF_EN
   ,output logic [PERF_W-1:0]          stall_cnt,
    output logic [PERF_W-1:0]          bubble_cnt
`endif
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t             LAST_PTR = ptr_t'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  data_mem  [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    ptr_t               rd_ptr;
    ptr_t               wr_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    // Explicit wrap so non-power-of-two depths skip the unused pointer codes.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // in_ready depends on registered occupancy only, never on out_ready.
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Empty stage presents a NOP bubble rather than stale entry contents.
    assign out_data  = out_valid ? data_mem[rd_ptr]  : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : INSTR_W'(NOP_INSTR);

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // NOTE: entry storage is deliberately not reset; occupancy alone decides
    // what is visible, so clearing the array would only cost reset fan-out.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            data_mem[wr_ptr]  <= in_data;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assert property (@(posedge CLK) disable iff (RST) count_q <= FULL);

`ifdef PIPE_BUF_PERF_EN
    pipe_buf_perf u_perf (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance,
// each tracked by a queue model; scenario tasks add inline spot checks.
module tb_pipe_stage_buf;

    localparam int DW = 16;
    localparam int IW = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_s     [2];
    logic          in_valid_s  [2];
    logic          in_ready_s  [2];
    logic [DW-1:0] in_data_s   [2];
    logic [IW-1:0] in_instr_s  [2];
    logic          out_valid_s [2];
    logic          out_ready_s [2];
    logic [DW-1:0] out_data_s  [2];
    logic [IW-1:0] out_instr_s [2];
    logic [1:0]    count_s     [2];
`ifdef PIPE_BUF_PERF_EN
    logic [31:0]   stall_s     [2];
    logic [31:0]   bubble_s    [2];
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t sb0[$];
    ent_t sb1[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .INSTR_W(IW)) u_d2 (
        .CLK(clk), .RST(rst), .flush(flush_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data_s[0]), .in_instr(in_instr_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_data(out_data_s[0]), .out_instr(out_instr_s[0]),
        .count(count_s[0])
`ifdef PIPE_BUF_PERF_EN
       ,.stall_cnt(stall_s[0]), .bubble_cnt(bubble_s[0])
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(3), .INSTR_W(IW)) u_d3 (
        .CLK(clk), .RST(rst), .flush(flush_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data_s[1]), .in_instr(in_instr_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_data(out_data_s[1]), .out_instr(out_instr_s[1]),
        .count(count_s[1])
`ifdef PIPE_BUF_PERF_EN
       ,.stall_cnt(stall_s[1]), .bubble_cnt(bubble_s[1])
`endif
    );

    function automatic int dep(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int sb_size(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic ent_t sb_front(input int k);
        return (k == 0) ? sb0[0] : sb1[0];
    endfunction

    function automatic logic [IW-1:0] tag(input logic [DW-1:0] d);
        return {16'hC0DE, d};
    endfunction

    // Queue model: decides push/pop from its own occupancy, never from the DUT.
    always @(negedge clk) begin
        int   sz;
        ent_t h;
        if (rst) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                sz = sb_size(k);
                checks++;
                if (count_s[k] !== 2'(sz)) begin
                    errors++;
                    $display("FAIL count[d%0d]: got %0d want %0d", k, count_s[k], sz);
                end
                checks++;
                if (int'(count_s[k]) > dep(k)) begin
                    errors++;
                    $display("FAIL count_overflow[d%0d]: got %0d depth %0d", k, count_s[k], dep(k));
                end
                checks++;
                if (in_ready_s[k] !== (sz != dep(k))) begin
                    errors++;
                    $display("FAIL in_ready[d%0d]: got %b want %b", k, in_ready_s[k], sz != dep(k));
                end
                checks++;
                if (out_valid_s[k] !== (sz != 0)) begin
                    errors++;
                    $display("FAIL out_valid[d%0d]: got %b want %b", k, out_valid_s[k], sz != 0);
                end
                checks++;
                if (sz == 0) begin
                    if (out_data_s[k] !== '0 || out_instr_s[k] !== '0) begin
                        errors++;
                        $display("FAIL bubble[d%0d]: got %h/%h want 0/0", k, out_data_s[k], out_instr_s[k]);
                    end
                end else begin
                    h = sb_front(k);
                    if (out_data_s[k] !== h.d || out_instr_s[k] !== h.i) begin
                        errors++;
                        $display("FAIL head[d%0d]: got %h/%h want %h/%h", k,
                                 out_data_s[k], out_instr_s[k], h.d, h.i);
                    end
                end
                if (flush_s[k]) begin
                    if (k == 0) sb0.delete(); else sb1.delete();
                end else begin
                    if (sz != 0 && out_ready_s[k]) begin
                        if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                    end
                    if (in_valid_s[k] && sz != dep(k)) begin
                        if (k == 0) sb0.push_back('{in_data_s[k], in_instr_s[k]});
                        else        sb1.push_back('{in_data_s[k], in_instr_s[k]});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [DW-1:0] d);
        in_valid_s[k] = v;
        in_data_s[k]  = d;
        in_instr_s[k] = tag(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 16'hDEAD);
        drive(1, 1'b1, 16'hBEEF);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid_s[0] !== 1'b0 || out_data_s[0] !== '0 || out_instr_s[0] !== '0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h i=%h want 0/0/0",
                     out_valid_s[0], out_data_s[0], out_instr_s[0]);
        end
        checks++;
        if (in_ready_s[0] !== 1'b1 || count_s[0] !== 2'd0 || count_s[1] !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b cnt=%0d/%0d want 1/0/0",
                     in_ready_s[0], count_s[0], count_s[1]);
        end
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        out_ready_s[0] = 1'b0;
        drive(0, 1'b1, 16'h0011); step();
        drive(0, 1'b1, 16'h0022); step();
        checks++;
        if (count_s[0] !== 2'd2 || in_ready_s[0] !== 1'b0 || out_data_s[0] !== 16'h0011) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b d=%h want 2/0/0011",
                     count_s[0], in_ready_s[0], out_data_s[0]);
        end
        drive(0, 1'b1, 16'h00CC); step();
        checks++;
        if (count_s[0] !== 2'd2 || out_data_s[0] !== 16'h0011) begin
            errors++;
            $display("FAIL fill_reject: got cnt=%0d d=%h want 2/0011", count_s[0], out_data_s[0]);
        end
        drive(0, 1'b0, '0);
        out_ready_s[0] = 1'b1;
        step();
        checks++;
        if (out_data_s[0] !== 16'h0022 || count_s[0] !== 2'd1) begin
            errors++;
            $display("FAIL fill_drain: got d=%h cnt=%0d want 0022/1", out_data_s[0], count_s[0]);
        end
        step();
    endtask

    task automatic test_stream();
        out_ready_s[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1'b1, DW'(i));
            step();
            checks++;
            if (out_data_s[0] !== DW'(i) || count_s[0] !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: got d=%h cnt=%0d want %h/1", i, out_data_s[0], count_s[0], DW'(i));
            end
        end
        drive(0, 1'b0, '0);
        step();
    endtask

    task automatic test_flush();
        out_ready_s[0] = 1'b0;
        drive(0, 1'b1, 16'h0044); step();
        drive(0, 1'b1, 16'h0055); step();
        flush_s[0] = 1'b1;
        drive(0, 1'b1, 16'h0033);
        step();
        flush_s[0] = 1'b0;
        drive(0, 1'b0, '0);
        checks++;
        if (count_s[0] !== 2'd0 || out_valid_s[0] !== 1'b0 || out_data_s[0] !== '0) begin
            errors++;
            $display("FAIL flush: got cnt=%0d v=%b d=%h want 0/0/0",
                     count_s[0], out_valid_s[0], out_data_s[0]);
        end
        out_ready_s[0] = 1'b1;
        step();
        checks++;
        if (out_valid_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: got v=%b d=%h want 0", out_valid_s[0], out_data_s[0]);
        end
    endtask

    task automatic test_wrap();
        out_ready_s[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1'b1, DW'(16'hA0 + i));
            step();
            checks++;
            if (out_data_s[1] !== DW'(16'hA0 + i)) begin
                errors++;
                $display("FAIL wrap_%0d: got %h want %h", i, out_data_s[1], DW'(16'hA0 + i));
            end
        end
        drive(1, 1'b0, '0);
        step();
        // Pointers now sit at 1; filling three entries wraps them again.
        out_ready_s[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, DW'(16'hB0 + i));
            step();
        end
        drive(1, 1'b0, '0);
        checks++;
        if (count_s[1] !== 2'd3 || in_ready_s[1] !== 1'b0 || out_data_s[1] !== 16'h00B0) begin
            errors++;
            $display("FAIL d3_full: got cnt=%0d rdy=%b d=%h want 3/0/00b0",
                     count_s[1], in_ready_s[1], out_data_s[1]);
        end
        out_ready_s[1] = 1'b1;
        step();
        step();
        checks++;
        if (out_data_s[1] !== 16'h00B2) begin
            errors++;
            $display("FAIL d3_order: got %h want 00b2", out_data_s[1]);
        end
        step();
    endtask

`ifdef PIPE_BUF_PERF_EN
    task automatic test_perf();
        out_ready_s[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stall_s[0] !== 32'd0 || bubble_s[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst0: got %0d/%0d want 0/0", stall_s[0], bubble_s[0]);
        end
        // Edge 1 is empty (bubble) while the entry is pushed; 5 stalled edges follow.
        drive(0, 1'b1, 16'h0077); step();
        drive(0, 1'b0, '0);
        repeat (5) step();
        out_ready_s[0] = 1'b1; step();
        out_ready_s[0] = 1'b0;
        repeat (3) step();
        checks++;
        if (stall_s[0] !== 32'd5 || bubble_s[0] !== 32'd4) begin
            errors++;
            $display("FAIL perf_count: got %0d/%0d want 5/4", stall_s[0], bubble_s[0]);
        end
        flush_s[0] = 1'b1; step();
        flush_s[0] = 1'b0;
        checks++;
        if (stall_s[0] !== 32'd5 || bubble_s[0] !== 32'd4) begin
            errors++;
            $display("FAIL perf_flush: got %0d/%0d want 5/4", stall_s[0], bubble_s[0]);
        end
        rst = 1'b1; step();
        rst = 1'b0;
        checks++;
        if (stall_s[0] !== 32'd0 || bubble_s[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: got %0d/%0d want 0/0", stall_s[0], bubble_s[0]);
        end
    endtask
`endif

    task automatic test_drain();
        int budget;
        out_ready_s[0] = 1'b1;
        out_ready_s[1] = 1'b1;
        budget = 10;
        while ((out_valid_s[0] || out_valid_s[1]) && budget > 0) begin
            step();
            budget--;
        end
        step();
        checks++;
        if (budget == 0 || sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL drain: got budget=%0d queued=%0d/%0d want >0/0/0",
                     budget, sb0.size(), sb1.size());
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            flush_s[k]     = 1'b0;
            out_ready_s[k] = 1'b0;
            drive(k, 1'b0, '0);
        end
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_wrap();
`ifdef PIPE_BUF_PERF_EN
        test_perf();
`endif
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
